uart_frame_dispatcher: RTL

Parametrised sample-to-module dispatcher between the SPI sample receiver and the bank of per-module UART transmitters. It requests one sample (12-bit sine index plus 4-bit module id), splits it into a two-byte frame, and sends it over `NUM_CH` UART channels. Each channel completes its own handshake, and a timeout guards every byte. A `shoot` pulse follows a fully delivered frame, then a pacing interval runs before the next request. Broadcast and addressed modes are supported.

---
 rtl/uart_frame_dispatcher.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_dispatcher.sv
`timescale 1ns/1ps
// uart_frame_dispatcher
// Pulls one 16-bit sample (12-bit sine index + 4-bit module id) from the SPI
// receiver and delivers it as a two-byte frame over a bank of UART
// transmitters. Each selected channel does its own start/busy handshake, and
// a timeout guards every byte. A clean frame is followed by a shoot pulse.
// A pacing gap then runs before the next sample request.
module uart_frame_dispatcher #(
    parameter int NUM_CH         = 9,
    parameter int PACE_CYCLES    = 256,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SHOOT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  addr_mode,
    input  logic [NUM_CH-1:0]     ch_enable,
    output logic                  sample_req,
    input  logic                  sample_valid,
    input  logic [11:0]           sin_index,
    input  logic [3:0]            uart_id,
    output logic [NUM_CH-1:0]     start_tx,
    output logic [8*NUM_CH-1:0]   data_to_tx,
    input  logic [NUM_CH-1:0]     tx_busy,
    output logic                  shoot,
    output logic                  busy,
    output logic [NUM_CH-1:0]     ch_error,
    input  logic                  err_clr
);

    // One shared counter serves the byte timeout, the shoot width and the pace gap.
    localparam int CNT_MAX_A = (PACE_CYCLES > TIMEOUT_CYCLES) ? PACE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > SHOOT_WIDTH) ? CNT_MAX_A : SHOOT_WIDTH;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOOT_LAST   = CNT_W'(SHOOT_WIDTH - 1);
    localparam logic [CNT_W-1:0] PACE_LAST    = CNT_W'(PACE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        SHOOT,
        PACE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [NUM_CH-1:0]  sel_reg, sel_next;
    logic [NUM_CH-1:0]  acked_reg, acked_next;
    logic [NUM_CH-1:0]  done_reg, done_next;
    logic [7:0]         byte_reg, byte_next;
    logic [7:0]         lo_byte_reg, lo_byte_next;
    logic [NUM_CH-1:0]  start_tx_reg, start_tx_next;
    logic               sample_req_reg, sample_req_next;
    logic               shoot_reg, shoot_next;
    logic               busy_reg, busy_next;
    logic [NUM_CH-1:0]  ch_error_reg, ch_error_next;

    logic [NUM_CH-1:0]  id_onehot;
    logic [NUM_CH-1:0]  capture_sel;
    logic               in_byte;

    // An id outside the channel range decodes to an empty mask, so the frame drops.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            assign id_onehot[gi]              = (uart_id == 4'(gi));
            assign data_to_tx[8*gi +: 8]      = byte_reg;
        end
    endgenerate

    assign capture_sel = addr_mode ? id_onehot : ch_enable;

    assign sample_req = sample_req_reg;
    assign start_tx   = start_tx_reg;
    assign shoot      = shoot_reg;
    assign busy       = busy_reg;
    assign ch_error   = ch_error_reg;

    // State register and every registered output, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            sel_reg        <= '0;
            acked_reg      <= '0;
            done_reg       <= '0;
            byte_reg       <= '0;
            lo_byte_reg    <= '0;
            start_tx_reg   <= '0;
            sample_req_reg <= 1'b0;
            shoot_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            ch_error_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            sel_reg        <= sel_next;
            acked_reg      <= acked_next;
            done_reg       <= done_next;
            byte_reg       <= byte_next;
            lo_byte_reg    <= lo_byte_next;
            start_tx_reg   <= start_tx_next;
            sample_req_reg <= sample_req_next;
            shoot_reg      <= shoot_next;
            busy_reg       <= busy_next;
            ch_error_reg   <= ch_error_next;
        end
    end

    // Next-state logic. Outputs are derived from the next state so they are registered without extra latency.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg + CNT_W'(1);
        sel_next      = sel_reg;
        acked_next    = acked_reg;
        done_next     = done_reg;
        byte_next     = byte_reg;
        lo_byte_next  = lo_byte_reg;
        ch_error_next = err_clr ? '0 : ch_error_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                cnt_next = '0;
                if (sample_valid) begin
                    sel_next     = capture_sel;
                    byte_next    = sin_index[11:4];
                    lo_byte_next = {sin_index[3:0], uart_id};
                    acked_next   = '0;
                    done_next    = '0;
                    state_next   = (capture_sel == '0) ? PACE : SEND_HI;
                end
            end
            SEND_HI, SEND_LO: begin
                // First cycle of a byte: handshake tracking restarts from scratch.
                acked_next = sel_reg & tx_busy;
                done_next  = '0;
                state_next = (state_reg == SEND_HI) ? WAIT_HI : WAIT_LO;
            end
            WAIT_HI, WAIT_LO: begin
                acked_next = acked_reg | (sel_reg & tx_busy);
                done_next  = done_reg | (acked_reg & ~tx_busy);
                if (done_reg == sel_reg) begin
                    cnt_next = '0;
                    if (state_reg == WAIT_HI) begin
                        state_next = SEND_LO;
                        byte_next  = lo_byte_reg;
                        acked_next = '0;
                        done_next  = '0;
                    end else begin
                        state_next = SHOOT;
                    end
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    // Blame only the channels that had not finished this byte.
                    ch_error_next = ch_error_next | (sel_reg & ~done_reg);
                    cnt_next      = '0;
                    state_next    = PACE;
                end
            end
            SHOOT: begin
                if (cnt_reg == SHOOT_LAST) begin
                    cnt_next   = '0;
                    state_next = PACE;
                end
            end
            PACE: begin
                if (cnt_reg == PACE_LAST) begin
                    cnt_next   = '0;
                    state_next = enable ? REQUEST : IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase

        in_byte = (state_next == SEND_HI) || (state_next == WAIT_HI) ||
                  (state_next == SEND_LO) || (state_next == WAIT_LO);

        sample_req_next = (state_next == REQUEST);
        shoot_next      = (state_next == SHOOT);
        busy_next       = (state_next != IDLE);
        start_tx_next   = in_byte ? (sel_next & ~acked_next) : '0;
    end

endmodule
